stream_demux_1to2: RTL and testbench

// - 1-to-2 stream demultiplexer; the inverse of the 2:1 select path.
// - Routes each accepted input word to output A (sel=0) or output B (sel=1).
// - Each output has a registered valid/ready skid slice, so in_ready never

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/stream_skid_slice.sv | 98 +++++++++
 rtl/stream_demux_1to2.sv | 75 +++++++
 tb/tb_stream_demux_1to2.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer and its skid slices.
// Destination encoding and the two-entry slice occupancy states.
package stream_demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

endpackage : stream_demux_pkg

// File: rtl/stream_skid_slice.sv
// Two-entry (main + skid) valid/ready slice; a write becomes visible on out_* one edge later.
// in_ready is a flop (registered !FULL), so it never depends combinationally on out_ready.
module stream_skid_slice
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    slice_state_t      state;
    slice_state_t      state_nxt;
    logic              ready_q;
    logic [DATA_W-1:0] main_dat;
    logic [DATA_W-1:0] skid_dat;

    logic wr;
    logic rd;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_dat;

    assign wr = in_valid && ready_q;
    assign rd = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (wr) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (wr && rd) begin
                    load_main_in = 1'b1;
                end else if (wr) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (rd) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // ready_q is low here, so no write can arrive alongside the read.
                if (rd) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            if (load_main_in) begin
                main_dat <= in_data;
            end else if (load_main_skid) begin
                main_dat <= skid_dat;
            end
            if (load_skid) begin
                skid_dat <= in_data;
            end
        end
    end

endmodule : stream_skid_slice

// File: rtl/stream_demux_1to2.sv
// Routes each accepted word to output A (sel=0) or B (sel=1) through a skid slice; 1 edge latency.
// in_ready follows the selected slice only, so a blocked destination stalls the input.
module stream_demux_1to2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    logic slice_a_ready;
    logic slice_b_ready;
    logic wr_a;
    logic wr_b;

    assign in_ready = (in_sel == SEL_B) ? slice_b_ready : slice_a_ready;
    assign wr_a     = in_valid && (in_sel == SEL_A);
    assign wr_b     = in_valid && (in_sel == SEL_B);

    stream_skid_slice #(
        .DATA_W (DATA_W)
    ) u_slice_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_a),
        .in_ready  (slice_a_ready),
        .in_data   (in_data),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .out_data  (out_a_data)
    );

    stream_skid_slice #(
        .DATA_W (DATA_W)
    ) u_slice_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (wr_b),
        .in_ready  (slice_b_ready),
        .in_data   (in_data),
        .out_valid (out_b_valid),
        .out_ready (out_b_ready),
        .out_data  (out_b_data)
    );

    // Delivery counters advance on the output handshake and wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (out_a_valid && out_a_ready) begin
                cnt_a <= cnt_a + CNT_W'(1);
            end
            if (out_b_valid && out_b_ready) begin
                cnt_b <= cnt_b + CNT_W'(1);
            end
        end
    end

endmodule : stream_demux_1to2

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2: per-output scoreboards plus hand-computed checks.
module tb_stream_demux_1to2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       out_a_valid;
    logic       out_a_ready;
    logic [7:0] out_a_data;
    logic       out_b_valid;
    logic       out_b_ready;
    logic [7:0] out_b_data;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    stream_demux_1to2 #(
        .DATA_W (8),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .out_b_data  (out_b_data),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a word and holds it until accepted; records it for its output's scoreboard.
    task automatic send(input logic s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        #1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                if (s) exp_b.push_back(d);
                else   exp_a.push_back(d);
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("rdy_before_edge", in_ready, 0);
        cyc(1);
        chk("rdy_after_edge", in_ready, 1);
    endtask

    // Output scoreboards and producer-stability check, sampled mid-cycle.
    logic       stall_q = 1'b0;
    logic [8:0] stall_dat = 9'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && in_valid) chk("in_stable", {in_sel, in_data}, stall_dat);
            if (out_a_valid && out_a_ready) begin
                if (exp_a.size() == 0) chk("a_extra", out_a_data, 32'hFFFF_FFFF);
                else                   chk("a_order", out_a_data, exp_a.pop_front());
            end
            if (out_b_valid && out_b_ready) begin
                if (exp_b.size() == 0) chk("b_extra", out_b_data, 32'hFFFF_FFFF);
                else                   chk("b_order", out_b_data, exp_b.pop_front());
            end
            stall_q   = in_valid && !in_ready;
            stall_dat = {in_sel, in_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [7:0] alt_dat [4];
    time        t0;

    initial begin
        alt_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_sel      = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_a_valid", out_a_valid, 0);
        chk("rst_b_valid", out_b_valid, 0);
        chk("rst_a_data", out_a_data, 0);
        chk("rst_b_data", out_b_data, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_in_ready", in_ready, 0);
        cyc(3);
        release_reset();

        // Alternating routing with both consumers ready
        for (int i = 0; i < 4; i++) begin
            send(i[0], alt_dat[i]);
            if (i[0]) begin
                chk("alt_b_valid", out_b_valid, 1);
                chk("alt_b_data", out_b_data, alt_dat[i]);
            end else begin
                chk("alt_a_valid", out_a_valid, 1);
                chk("alt_a_data", out_a_data, alt_dat[i]);
            end
        end
        idle();
        cyc(3);
        chk("alt_cnt_a", cnt_a, 2);
        chk("alt_cnt_b", cnt_b, 2);

        // Backpressure on A: two words fit, the third waits
        out_a_ready = 1'b0;
        send(0, 8'hA1);
        chk("bp_rdy_one", in_ready, 1);
        send(0, 8'hA2);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'hA3;
        #1;
        chk("bp_rdy_full", in_ready, 0);
        chk("bp_a_head", out_a_data, 8'hA1);

        // Head-of-line blocking: B idle while the A-bound head word waits
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("hol_in_ready", in_ready, 0);
            chk("hol_b_valid", out_b_valid, 0);
        end
        chk("hol_cnt_a", cnt_a, 2);
        out_a_ready = 1'b1;
        send(0, 8'hA3);
        idle();
        cyc(4);
        chk("bp_cnt_a", cnt_a, 5);
        chk("bp_a_drained", exp_a.size(), 0);

        // Read and write together while in ONE
        send(0, 8'hB1);
        send(0, 8'hB2);
        chk("rw_a_data", out_a_data, 8'hB2);
        chk("rw_a_valid", out_a_valid, 1);
        chk("rw_cnt_a", cnt_a, 6);
        chk("rw_stay_one", in_ready, 1);
        idle();
        cyc(3);
        chk("rw_cnt_a_end", cnt_a, 7);

        // Counter wrap on B from a fresh reset, 1 word/cycle
        rst_n = 1'b0;
        cyc(2);
        release_reset();
        t0 = $time;
        for (int i = 0; i < 255; i++) send(1, 8'(i));
        chk("thru_cycles", 32'(($time - t0) / 10), 255);
        idle();
        cyc(3);
        chk("wrap_cnt_b_255", cnt_b, 255);
        send(1, 8'hFF);
        idle();
        cyc(3);
        chk("wrap_cnt_b_0", cnt_b, 0);
        chk("wrap_cnt_a", cnt_a, 0);

        // Asynchronous reset with both slices FULL
        send(0, 8'h01);
        send(1, 8'h02);
        idle();
        cyc(3);
        chk("pre_cnt_a", cnt_a, 1);
        chk("pre_cnt_b", cnt_b, 1);
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        send(0, 8'hC1);
        send(0, 8'hC2);
        send(1, 8'hD1);
        send(1, 8'hD2);
        chk("full_in_ready", in_ready, 0);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ar_a_valid", out_a_valid, 0);
        chk("ar_b_valid", out_b_valid, 0);
        chk("ar_cnt_a", cnt_a, 0);
        chk("ar_cnt_b", cnt_b, 0);
        chk("ar_a_data", out_a_data, 0);
        chk("ar_in_ready", in_ready, 0);
        exp_a.delete();
        exp_b.delete();
        cyc(2);
        release_reset();
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        send(0, 8'hE1);
        send(1, 8'hE2);
        idle();
        cyc(3);
        chk("post_cnt_a", cnt_a, 1);
        chk("post_cnt_b", cnt_b, 1);
        chk("post_a_drained", exp_a.size(), 0);
        chk("post_b_drained", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_demux_1to2
